// File: rtl/usb3_ep_reader.sv
// Read-side drain engine for a usb3_ep double-buffered endpoint: buffer words -> valid/ready stream, then arm/ack release.
// Optional live packet counter enabled by defining USB3_EP_READER_PKTCNT_EN (otherwise pkt_count is tied to 0).
module usb3_ep_reader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        local_clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [8:0]  buf_out_addr,
  input  logic [31:0] buf_out_q,
  input  logic [10:0] buf_out_len,
  input  logic        buf_out_hasdata,
  output logic        buf_out_arm,
  input  logic        buf_out_arm_ack,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [3:0]  tx_be,
  output logic        busy,
  output logic [15:0] pkt_count
);

  localparam logic [10:0] LEN_MAX = 11'(4 * MAX_WORDS);

  typedef enum logic [1:0] {IDLE, STREAM, ARM, ARM_WAIT} state_t;

  state_t state_q, state_d;

  function automatic logic [10:0] clamp_len(input logic [10:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

  function automatic logic [8:0] len_to_words(input logic [10:0] len);
    return len[10:2] + {8'd0, |len[1:0]};
  endfunction

  function automatic logic [3:0] last_be(input logic [1:0] lo);
    case (lo)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  logic [10:0] len_clamp;
  logic [8:0]  words_start;
  logic        start;

  logic [8:0]  words_q;
  logic [1:0]  len_lo_q;
  logic        zlp_q;
  logic [8:0]  iss_cnt_q;
  logic [8:0]  out_cnt_q;
  logic        rd_vld_p0;
  logic [1:0]  skid_cnt_q;
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [31:0] skid_data_p1 [2];

  logic        in_stream;
  logic        pop;
  logic        pop_skid;
  logic        last_acc;
  logic        issue;
  logic [2:0]  occ;

  assign len_clamp   = clamp_len(buf_out_len);
  assign words_start = len_to_words(len_clamp);
  assign start       = (state_q == IDLE) && enable && buf_out_hasdata;

  assign in_stream = (state_q == STREAM);
  assign tx_valid  = in_stream && (zlp_q || (skid_cnt_q != 2'd0));
  assign pop       = tx_valid && tx_ready;
  assign pop_skid  = pop && !zlp_q;
  assign tx_last   = tx_valid && (zlp_q || (out_cnt_q == words_q - 9'd1));
  assign last_acc  = pop && tx_last;

  // Occupancy after this cycle's pop lets the prefetch keep one read in flight at full rate.
  assign occ   = {1'b0, skid_cnt_q} + {2'b0, rd_vld_p0} - {2'b0, pop_skid};
  assign issue = in_stream && (iss_cnt_q < words_q) && (occ < 3'd2);

  assign tx_data     = (tx_valid && !zlp_q) ? skid_data_p1[rd_ptr_q] : 32'd0;
  assign tx_be       = (!tx_valid || zlp_q) ? 4'b0000 :
                       (tx_last ? last_be(len_lo_q) : 4'b1111);
  assign busy        = (state_q != IDLE);
  assign buf_out_arm = (state_q == ARM);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = STREAM;
      STREAM:   if (last_acc) state_d = ARM;
      ARM:      if (buf_out_arm_ack) state_d = ARM_WAIT;
      ARM_WAIT: if (!buf_out_arm_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Stage p0: address issue and in-flight read tracking
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      words_q      <= 9'd0;
      len_lo_q     <= 2'd0;
      zlp_q        <= 1'b0;
      iss_cnt_q    <= 9'd0;
      out_cnt_q    <= 9'd0;
      buf_out_addr <= 9'd0;
      rd_vld_p0    <= 1'b0;
      skid_cnt_q   <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        words_q      <= words_start;
        len_lo_q     <= len_clamp[1:0];
        zlp_q        <= (len_clamp == 11'd0);
        iss_cnt_q    <= 9'd0;
        out_cnt_q    <= 9'd0;
        buf_out_addr <= 9'd0;
        rd_vld_p0    <= 1'b0;
        skid_cnt_q   <= 2'd0;
        wr_ptr_q     <= 1'b0;
        rd_ptr_q     <= 1'b0;
      end else begin
        rd_vld_p0 <= issue;
        if (issue) begin
          iss_cnt_q <= iss_cnt_q + 9'd1;
          if (iss_cnt_q + 9'd1 < words_q) buf_out_addr <= buf_out_addr + 9'd1;
        end
        if (rd_vld_p0) wr_ptr_q <= ~wr_ptr_q;
        if (pop_skid) rd_ptr_q <= ~rd_ptr_q;
        skid_cnt_q <= skid_cnt_q + {1'b0, rd_vld_p0} - {1'b0, pop_skid};
        if (pop) out_cnt_q <= out_cnt_q + 9'd1;
        if (last_acc) zlp_q <= 1'b0;
      end
    end
  end

  // Stage p1: read data lands in the skid; occupancy gating means no unread entry is overwritten
  always_ff @(posedge local_clk) begin
    if (rd_vld_p0) skid_data_p1[wr_ptr_q] <= buf_out_q;
  end

`ifdef USB3_EP_READER_PKTCNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q <= 16'd0;
    end else if (last_acc) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_count = pkt_cnt_q;
`else
  assign pkt_count = 16'd0;
`endif

endmodule

// File: tb/tb_usb3_ep_reader.sv
// Directed bench for usb3_ep_reader: BRAM/endpoint model with immediate-assertion checks.
module tb_usb3_ep_reader;

  logic        local_clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [8:0]  buf_out_addr;
  logic [31:0] buf_out_q;
  logic [10:0] buf_out_len;
  logic        buf_out_hasdata;
  logic        buf_out_arm;
  logic        buf_out_arm_ack;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic [3:0]  tx_be;
  logic        busy;
  logic [15:0] pkt_count;

  logic [15:0] seed;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_cnt = 0;

  always #5 local_clk = ~local_clk;

  // Buffer word i holds {seed, 7'b0, i}
  always @(posedge local_clk) buf_out_q <= {seed, 7'd0, buf_out_addr};

  usb3_ep_reader #(.MAX_WORDS(256)) dut (
    .local_clk       (local_clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .buf_out_addr    (buf_out_addr),
    .buf_out_q       (buf_out_q),
    .buf_out_len     (buf_out_len),
    .buf_out_hasdata (buf_out_hasdata),
    .buf_out_arm     (buf_out_arm),
    .buf_out_arm_ack (buf_out_arm_ack),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_last         (tx_last),
    .tx_be           (tx_be),
    .busy            (busy),
    .pkt_count       (pkt_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] be_of(input int r);
    case (r)
      1:       return 4'b0001;
      2:       return 4'b0011;
      3:       return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] cnt_exp();
`ifdef USB3_EP_READER_PKTCNT_EN
    return 32'(exp_cnt & 16'hFFFF);
`else
    return 32'd0;
`endif
  endfunction

  // Start inputs must already be applied at the current negedge.
  task automatic stream_pkt(input int len, input bit toggle, input int lat);
    int clen, nb, beat, cyc, first;
    bit zlp, stall;
    logic [31:0] sd, ed;
    logic [3:0]  sbe, ebe;
    logic        sl;
    clen  = (len > 1024) ? 1024 : len;
    zlp   = (clen == 0);
    nb    = zlp ? 1 : (clen + 3) / 4;
    beat  = 0; cyc = 0; first = 0; stall = 0;
    sd = 32'd0; sbe = 4'd0; sl = 1'b0;
    tx_ready = toggle ? 1'b0 : 1'b1;
    while (beat < nb && cyc < 1000) begin
      @(negedge local_clk);
      cyc++;
      if (stall) begin
        chk("hold_data", tx_data, sd);
        chk("hold_be", 32'(tx_be), 32'(sbe));
        chk("hold_last", 32'(tx_last), 32'(sl));
      end
      if (tx_valid && first == 0) first = cyc;
      if (zlp) chk("zlp_addr", 32'(buf_out_addr), 32'd0);
      tx_ready = toggle ? ~tx_ready : 1'b1;
      if (tx_valid && tx_ready) begin
        ed  = zlp ? 32'd0 : {seed, 7'd0, 9'(beat)};
        ebe = zlp ? 4'b0000 : ((beat == nb - 1) ? be_of(clen % 4) : 4'b1111);
        chk("beat_data", tx_data, ed);
        chk("beat_be", 32'(tx_be), 32'(ebe));
        chk("beat_last", 32'(tx_last), 32'(beat == nb - 1));
        beat++;
      end
      stall = tx_valid && !tx_ready;
      sd = tx_data; sbe = tx_be; sl = tx_last;
    end
    chk("beat_count", 32'(beat), 32'(nb));
    if (lat != 0) chk("first_valid_lat", 32'(first), 32'(lat));
  endtask

  // Called at the negedge whose following posedge accepts the last beat.
  task automatic arm_handshake(input int exp_addr, input int next_len, input bit next_has);
    @(negedge local_clk);
    exp_cnt++;
    chk("arm_rise", 32'(buf_out_arm), 32'd1);
    chk("addr_final", 32'(buf_out_addr), 32'(exp_addr));
    chk("pkt_count", 32'(pkt_count), cnt_exp());
    chk("valid_after_last", 32'(tx_valid), 32'd0);
    @(negedge local_clk);
    chk("arm_hold", 32'(buf_out_arm), 32'd1);
    buf_out_arm_ack = 1'b1;
    buf_out_len     = 11'(next_len);
    buf_out_hasdata = next_has;
    seed            = seed + 16'h1111;
    @(negedge local_clk);
    chk("arm_fall", 32'(buf_out_arm), 32'd0);
    chk("busy_arm_wait", 32'(busy), 32'd1);
    repeat (3) @(negedge local_clk);
    chk("busy_ack_high", 32'(busy), 32'd1);
    buf_out_arm_ack = 1'b0;
    @(negedge local_clk);
    chk("idle_after_ack", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_last"}, 32'(tx_last), 32'd0);
    chk({tag, "_be"}, 32'(tx_be), 32'd0);
    chk({tag, "_data"}, tx_data, 32'd0);
    chk({tag, "_addr"}, 32'(buf_out_addr), 32'd0);
    chk({tag, "_arm"}, 32'(buf_out_arm), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pktcnt"}, 32'(pkt_count), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cyc;
    reset_n = 1'b0; enable = 1'b0; buf_out_len = 11'd0; buf_out_hasdata = 1'b0;
    buf_out_arm_ack = 1'b0; tx_ready = 1'b0; seed = 16'hA0A0;
    repeat (3) @(negedge local_clk);
    chk_reset_outputs("por");
    reset_n = 1'b1;

    // enable low blocks a start
    buf_out_len = 11'd12; buf_out_hasdata = 1'b1;
    repeat (3) @(negedge local_clk);
    chk("enable_low_idle", 32'(busy), 32'd0);

    // back-to-back len 8 then len 5
    buf_out_len = 11'd8; enable = 1'b1;
    stream_pkt(8, 1'b0, 3);
    arm_handshake(1, 5, 1'b1);
    stream_pkt(5, 1'b0, 3);
    arm_handshake(1, 0, 1'b0);

    // len 12 at full rate
    buf_out_len = 11'd12; buf_out_hasdata = 1'b1;
    stream_pkt(12, 1'b0, 3);
    arm_handshake(2, 0, 1'b0);

    // len 7 with ready toggling
    buf_out_len = 11'd7; buf_out_hasdata = 1'b1;
    stream_pkt(7, 1'b1, 3);
    arm_handshake(1, 0, 1'b0);

    // zero-length packet
    buf_out_len = 11'd0; buf_out_hasdata = 1'b1;
    stream_pkt(0, 1'b0, 0);
    arm_handshake(0, 0, 1'b0);

    // oversize length clamps to 256 words
    buf_out_len = 11'd1100; buf_out_hasdata = 1'b1;
    stream_pkt(1100, 1'b0, 3);
    arm_handshake(255, 0, 1'b0);

    // reset mid-stream after 3 beats of a 10-beat packet
    buf_out_len = 11'd40; buf_out_hasdata = 1'b1; tx_ready = 1'b1;
    acc = 0; cyc = 0;
    while (acc < 3 && cyc < 100) begin
      @(negedge local_clk);
      cyc++;
      if (tx_valid && tx_ready) acc++;
    end
    @(negedge local_clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    chk("pre_reset_valid", 32'(tx_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    exp_cnt = 0;
    @(negedge local_clk);
    reset_n = 1'b1;
    stream_pkt(40, 1'b0, 3);
    arm_handshake(9, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usb3_ep_reader.md
# usb3_ep_reader

Drain engine for the read side of a usb3_ep double-buffered endpoint, running in the endpoint's local_clk domain. When the endpoint reports a filled buffer, the block reads it word by word through buf_out_addr/buf_out_q and presents it as a valid/ready packet stream with last-beat byte enables. It then arms the endpoint to release the buffer and waits for the arm handshake to complete before it starts the next packet.

## Interface
- MAX_WORDS, 256, buffer capacity in 32-bit words; larger lengths are clamped to this.
- local_clk  in  1  sole clock; also the endpoint rd_clk.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits new packets to start.
- buf_out_addr  out  9  word address into the current buffer.
- buf_out_q  in  32  endpoint read data, valid 1 cycle after the address edge.
- buf_out_len  in  11  packet length in bytes.
- buf_out_hasdata  in  1  current buffer holds a packet.
- buf_out_arm  out  1  request to release the buffer.
- buf_out_arm_ack  in  1  endpoint acknowledge, high for at least 4 cycles.
- tx_data  out  32  stream word.
- tx_valid  out  1  stream beat valid.
- tx_ready  in  1  downstream accept.
- tx_last  out  1  final beat of the packet.
- tx_be  out  4  byte enables; 4'b1111 except on the last beat.
- busy  out  1  high in every state except IDLE.
- pkt_count  out  16  number of completed packets (see Configuration).

## Operation
- States: IDLE, STREAM, ARM, ARM_WAIT.
- IDLE:
  - Leaves only when enable and buf_out_hasdata are both high.
  - On that edge: latch len = min(buf_out_len, 4*MAX_WORDS), words = ceil(len/4), addr = 0; go to STREAM.
- STREAM:
  - Pipelined prefetch feeding a 2-entry output skid.
  - A new address is issued only if skid occupancy plus in-flight reads is below 2.
  - buf_out_addr increments by 1 per issued read and stops after words-1.
- tx_last is asserted on beat words-1.
- tx_be on the last beat, by len[1:0]: 0 gives 1111, 1 gives 0001, 2 gives 0011, 3 gives 0111.
- Zero-length packet (len = 0):
  - One beat with tx_data = 0, tx_be = 0000, tx_last = 1.
  - No BRAM read is issued.
- Once the last beat is accepted (tx_valid & tx_ready), go to ARM.
- ARM: buf_out_arm = 1 and is held there. When buf_out_arm_ack = 1 is sampled, drop arm and go to ARM_WAIT.
- ARM_WAIT: wait for buf_out_arm_ack = 0, then go to IDLE. By then hasdata already reflects the swapped buffer.
- Deasserting enable mid-packet has no effect on that packet; it only blocks the next start.
- tx_data, tx_last and tx_be hold stable while tx_valid & ~tx_ready.

## Timing
- Values forced by reset:
  - state = IDLE.
  - buf_out_addr = 0, buf_out_arm = 0.
  - tx_valid = 0, tx_last = 0, tx_be = 0, tx_data = 0.
  - busy = 0, pkt_count = 0.
  - Skid buffer emptied.
- Reset assertion takes effect asynchronously at any point, including mid-STREAM or mid-ARM. A packet interrupted this way is lost; the endpoint still holds it, because no arm was issued.
- Latency: hasdata is sampled at edge E0, addr 0 is driven after E0, and tx_valid first rises after E0+2.
- Throughput: 1 word/cycle while tx_ready is held high.
  - Stalls of any length lose no data.
  - Resuming after a stall costs no extra bubble.
- Arm:
  - buf_out_arm rises on the cycle after the last-beat accept.
  - It falls on the cycle after ack is sampled high.
  - The earliest next start is 1 cycle after ack is sampled low.
- pkt_count increments on the last-beat accept and wraps 16'hFFFF to 0.

## Configuration
- USB3_EP_READER_PKTCNT_EN:
  - Defined: pkt_count is a live 16-bit counter as specified.
  - Undefined: pkt_count is tied to 0 and the counter logic is removed.

## Test plan
- len = 12, buffer words A0..A2, tx_ready = 1: 3 consecutive beats, tx_be = 1111 on all, tx_last on A2; first valid at E0+2; buf_out_arm pulses until ack.
- len = 7, tx_ready toggling 1/0 every cycle: 2 beats in order, last beat tx_be = 0111, data held stable during stalls.
- len = 0: a single beat with data 0, tx_be = 0000, tx_last = 1; no addr change; arm handshake completes.
- len = 1100: clamped to 256 beats, last tx_be = 1111, buf_out_addr ends at 255.
- Back-to-back packets of len 8 and 5: second starts after ack falls; pkt_count goes 0 to 2 (macro on), stays 0 (macro off).
- reset_n low mid-STREAM at beat 3 of 10: all outputs take their reset values immediately; after release with hasdata still 1, the full packet restarts from addr 0.
